servo_timebase_ctrl: RTL and testbench
======================================

// Module: servo_timebase_ctrl
// PURPOSE
//   Single-clock front end for the servo driver. Divides the system clock into the 1 us and 1 ms
//   time bases that the servo stage samples as timer_us / timer_ms (square waves), plus one-cycle
//   tick strobes. Owns the speed/step control registers: commands arrive over a valid/ready
//   handshake and are applied only on a millisecond boundary, so the servo never sees a mid-ms change.
// PARAMETERS
//   CLK_HZ        50_000_000  system clock frequency; US_DIV = CLK_HZ/1_000_000, must be >= 2 and integral
//   US_PER_MS     1000        timer_us periods per timer_ms period, >= 2
//   SPEED_DEFAULT 8'd10       speed value driven after reset (ms between angle steps)
//   STEP_DEFAULT  1'b1        step value driven after reset
// PORTS
//   clk        in   1  system clock, all logic on posedge
//   rst        in   1  synchronous, active-high reset
//   en         in   1  time-base enable; 0 freezes both dividers
//   cmd_valid  in   1  command present
//   cmd_ready  out  1  block can accept a command (= !pending, forced 0 while rst)
//   cmd_speed  in   8  new speed value
//   cmd_step   in   1  new step value
//   tick_us    out  1  one-clock strobe per microsecond
//   tick_ms    out  1  one-clock strobe per millisecond
//   timer_us   out  1  1 us square wave to the servo stage
//   timer_ms   out  1  1 ms square wave to the servo stage
//   speed      out  8  active speed value to the servo stage
//   step       out  1  active step value to the servo stage
//   pending    out  1  accepted command awaiting the next ms boundary
// BEHAVIOUR
//   Reset: pre_cnt=0, ms_cnt=0, tick_us=tick_ms=timer_us=timer_ms=0, pending=0,
//     speed=SPEED_DEFAULT, step=STEP_DEFAULT. Reset mid-operation discards any pending command.
//   Prescaler pre_cnt, width $clog2(US_DIV): increments on en cycles; wraps at US_DIV-1 -> 0.
//     tick_us is registered: high for exactly one clock, the cycle after pre_cnt==US_DIV-1 with en=1.
//     First tick_us occurs US_DIV clocks after rst deasserts with en=1.
//   ms_cnt, width $clog2(US_PER_MS): increments on each internal us wrap, wraps at US_PER_MS-1.
//     tick_ms is registered and coincides with the tick_us that completes the ms.
//   timer_us is registered: 1 while pre_cnt < US_DIV/2, else 0 (period US_DIV, rising edge at wrap).
//   timer_ms is registered: 1 while ms_cnt < US_PER_MS/2, else 0 (period US_DIV*US_PER_MS).
//   en=0: counters hold, tick_us/tick_ms are 0, timer_us/timer_ms hold their level; commands are
//     still accepted; pending holds.
//   Command path, two states IDLE (pending=0) and PEND (pending=1):
//     IDLE: cmd_valid & cmd_ready -> latch cmd_speed/cmd_step into shadow regs, go to PEND.
//     PEND: cmd_ready=0, further cmd_valid is ignored (not queued). On the first tick_ms strictly
//       after acceptance: speed<=shadow_speed, step<=shadow_step, go to IDLE (the outputs and
//       pending update on the clock edge following that tick_ms cycle).
//     An accept in the same cycle as tick_ms waits for the following tick_ms.
//   cmd_speed=0 is legal and passed through unchanged; there is no range checking.
//   speed/step change only at reset or at a ms boundary; never glitch between.
// TESTING (CLK_HZ=4_000_000 -> US_DIV=4, US_PER_MS=10 for sim speed)
//   1 rst high 3 clks then low, en=1 -> tick_us at clks 4,8,12..; tick_ms at clk 40,80;
//     timer_us 2 high/2 low; timer_ms 20 high/20 low; speed=10, step=1.
//   2 at clk 13 send speed=25, step=0 -> cmd_ready 0 from clk 14, speed stays 10 through clk 40,
//     speed=25, step=0 and pending=0 from clk 41.
//   3 while pending, send speed=99 -> ignored; speed=25 applied at the boundary, never 99.
//   4 drop en for 100 clks mid-ms -> no ticks during the gap; next tick_ms 100 clks later than
//     nominal; timer levels frozen.
//   5 accept a command, then pulse rst before the boundary -> pending=0, speed=10, step=1,
//     and the command is never applied.
//   6 assert cmd_valid exactly in a tick_ms cycle -> accepted; applied at the next tick_ms
//     (US_DIV*US_PER_MS=40 clks later), not the current one.

Source files
------------

// File: rtl/servo_timebase_ctrl_if.sv
// Command handshake bundle for the servo time-base controller.
// master drives valid/speed/step, slave answers with ready.
interface servo_timebase_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_speed;
    logic       cmd_step;

    modport master (
        output cmd_valid,
        output cmd_speed,
        output cmd_step,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_speed,
        input  cmd_step,
        output cmd_ready
    );
endinterface

// File: rtl/servo_timebase_ctrl.sv
// Servo front end: 1 us / 1 ms time bases, tick strobes, and speed/step
// registers that only change on a millisecond boundary.
// Ports: clk, rst (sync, active high), en (divider enable),
//   cmd (slave handshake: valid/ready/speed/step),
//   tick_us/tick_ms strobes, timer_us/timer_ms square waves,
//   speed/step active values, pending (command waiting for boundary).
module servo_timebase_ctrl #(
    parameter int         CLK_HZ        = 50_000_000,
    parameter int         US_PER_MS     = 1000,
    parameter logic [7:0] SPEED_DEFAULT = 8'd10,
    parameter logic       STEP_DEFAULT  = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    servo_timebase_ctrl_if.slave        cmd,
    output logic                        tick_us,
    output logic                        tick_ms,
    output logic                        timer_us,
    output logic                        timer_ms,
    output logic [7:0]                  speed,
    output logic                        step,
    output logic                        pending
);
    localparam int US_DIV = CLK_HZ / 1_000_000;
    localparam int PW     = $clog2(US_DIV);
    localparam int MW     = $clog2(US_PER_MS);

    localparam logic [PW-1:0] PRE_MAX  = PW'(US_DIV - 1);
    localparam logic [PW-1:0] PRE_HALF = PW'(US_DIV / 2);
    localparam logic [MW-1:0] MS_MAX   = MW'(US_PER_MS - 1);
    localparam logic [MW-1:0] MS_HALF  = MW'(US_PER_MS / 2);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] PEND = 1'b1;

    logic [PW-1:0] pre_cnt_q, pre_cnt_d;
    logic [MW-1:0] ms_cnt_q, ms_cnt_d;
    logic          tick_us_q, tick_us_d;
    logic          tick_ms_q, tick_ms_d;
    logic          timer_us_q, timer_us_d;
    logic          timer_ms_q, timer_ms_d;
    logic [0:0]    state_q, state_d;
    logic [7:0]    speed_q, speed_d;
    logic          step_q, step_d;
    logic [7:0]    sh_speed_q, sh_speed_d;
    logic          sh_step_q, sh_step_d;

    logic pre_wrap;
    logic ms_wrap;
    logic accept;

    assign cmd.cmd_ready = (state_q == IDLE) && !rst;
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;

    always_comb begin
        pre_wrap   = en && (pre_cnt_q == PRE_MAX);
        ms_wrap    = pre_wrap && (ms_cnt_q == MS_MAX);
        pre_cnt_d  = pre_cnt_q;
        ms_cnt_d   = ms_cnt_q;
        timer_us_d = timer_us_q;
        timer_ms_d = timer_ms_q;
        if (en) begin
            pre_cnt_d = pre_wrap ? '0 : pre_cnt_q + PW'(1);
            if (pre_wrap) begin
                ms_cnt_d = ms_wrap ? '0 : ms_cnt_q + MW'(1);
            end
            // Levels follow the next count so the rising edge
            // lines up with the wrap that produces the tick.
            timer_us_d = (pre_cnt_d < PRE_HALF);
            timer_ms_d = (ms_cnt_d < MS_HALF);
        end
        tick_us_d = pre_wrap;
        tick_ms_d = ms_wrap;
    end

    always_comb begin
        state_d    = state_q;
        speed_d    = speed_q;
        step_d     = step_q;
        sh_speed_d = sh_speed_q;
        sh_step_d  = sh_step_q;
        unique case (1'b1)
            (state_q == IDLE): begin
                if (accept) begin
                    sh_speed_d = cmd.cmd_speed;
                    sh_step_d  = cmd.cmd_step;
                    state_d    = PEND;
                end
            end
            default: begin
                // tick_ms_q is the registered strobe, so an accept
                // during a tick cycle can only match the next one.
                if (tick_ms_q) begin
                    speed_d = sh_speed_q;
                    step_d  = sh_step_q;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt_q  <= '0;
            ms_cnt_q   <= '0;
            tick_us_q  <= 1'b0;
            tick_ms_q  <= 1'b0;
            timer_us_q <= 1'b0;
            timer_ms_q <= 1'b0;
            state_q    <= IDLE;
            speed_q    <= SPEED_DEFAULT;
            step_q     <= STEP_DEFAULT;
            sh_speed_q <= SPEED_DEFAULT;
            sh_step_q  <= STEP_DEFAULT;
        end else begin
            pre_cnt_q  <= pre_cnt_d;
            ms_cnt_q   <= ms_cnt_d;
            tick_us_q  <= tick_us_d;
            tick_ms_q  <= tick_ms_d;
            timer_us_q <= timer_us_d;
            timer_ms_q <= timer_ms_d;
            state_q    <= state_d;
            speed_q    <= speed_d;
            step_q     <= step_d;
            sh_speed_q <= sh_speed_d;
            sh_step_q  <= sh_step_d;
        end
    end

    assign tick_us  = tick_us_q;
    assign tick_ms  = tick_ms_q;
    assign timer_us = timer_us_q;
    assign timer_ms = timer_ms_q;
    assign speed    = speed_q;
    assign step     = step_q;
    assign pending  = (state_q == PEND);
endmodule

// File: tb/tb_servo_timebase_ctrl.sv
// Self-checking bench for servo_timebase_ctrl (US_DIV=4, US_PER_MS=10).
// Reference model counts enabled cycles and derives everything from that.
module tb_servo_timebase_ctrl;
    localparam int DIV  = 4;
    localparam int UPM  = 10;
    localparam int MSP  = DIV * UPM;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       tick_us, tick_ms, timer_us, timer_ms;
    logic [7:0] speed;
    logic       step;
    logic       pending;

    servo_timebase_ctrl_if cif ();

    servo_timebase_ctrl #(
        .CLK_HZ       (4_000_000),
        .US_PER_MS    (UPM),
        .SPEED_DEFAULT(8'd10),
        .STEP_DEFAULT (1'b1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .cmd     (cif.slave),
        .tick_us (tick_us),
        .tick_ms (tick_ms),
        .timer_us(timer_us),
        .timer_ms(timer_ms),
        .speed   (speed),
        .step    (step),
        .pending (pending)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: n = enabled clock edges since reset
    int         n;
    logic       m_tus, m_tms;
    logic       m_pend;
    logic [7:0] m_speed, m_sh_speed;
    logic       m_step, m_sh_step;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input logic r, input logic e,
                       input logic v, input logic [7:0] s,
                       input logic st);
        logic acc;
        logic apply;
        rst           = r;
        en            = e;
        cif.cmd_valid = v;
        cif.cmd_speed = s;
        cif.cmd_step  = st;
        #1;
        check("cmd_ready", 32'(cif.cmd_ready), 32'(!m_pend && !r));
        acc = v && !m_pend && !r;
        @(posedge clk);
        if (r) begin
            n       = 0;
            m_tus   = 1'b0;
            m_tms   = 1'b0;
            m_pend  = 1'b0;
            m_speed = 8'd10;
            m_step  = 1'b1;
        end else begin
            apply = m_pend && m_tms;
            if (apply) begin
                m_speed = m_sh_speed;
                m_step  = m_sh_step;
                m_pend  = 1'b0;
            end
            if (acc) begin
                m_sh_speed = s;
                m_sh_step  = st;
                m_pend     = 1'b1;
            end
            if (e) begin
                n++;
                m_tus = (n % DIV) == 0;
                m_tms = (n % MSP) == 0;
            end else begin
                m_tus = 1'b0;
                m_tms = 1'b0;
            end
        end
        #1;
        check("tick_us", 32'(tick_us), 32'(m_tus));
        check("tick_ms", 32'(tick_ms), 32'(m_tms));
        check("timer_us", 32'(timer_us),
              32'((n != 0) && ((n % DIV) < DIV / 2)));
        check("timer_ms", 32'(timer_ms),
              32'((n != 0) && (((n / DIV) % UPM) < UPM / 2)));
        check("speed", 32'(speed), 32'(m_speed));
        check("step", 32'(step), 32'(m_step));
        check("pending", 32'(pending), 32'(m_pend));
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    endtask

    // Run until the model says tick_ms is high now; bounded.
    task automatic to_tick_ms();
        int k;
        k = 0;
        while (!m_tms && k < 3 * MSP) begin
            cyc(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
            k++;
        end
        check("tick_ms_reached", 32'(m_tms), 32'd1);
    endtask

    initial begin
        n          = 0;
        m_tus      = 1'b0;
        m_tms      = 1'b0;
        m_pend     = 1'b0;
        m_speed    = 8'd10;
        m_step     = 1'b1;
        m_sh_speed = 8'd10;
        m_sh_step  = 1'b1;

        // 1: reset then free-run
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
        check("rst_speed", 32'(speed), 32'd10);
        check("rst_step", 32'(step), 32'd1);
        idle(12);

        // 2: command at clk 13, applied after tick_ms at 40
        cyc(1'b0, 1'b1, 1'b1, 8'd25, 1'b0);
        check("pend_set", 32'(pending), 32'd1);
        idle(26);
        check("speed_hold", 32'(speed), 32'd10);
        idle(2);
        check("speed_new", 32'(speed), 32'd25);
        check("step_new", 32'(step), 32'd0);

        // 3: second command ignored while pending
        cyc(1'b0, 1'b1, 1'b1, 8'd25, 1'b1);
        idle(3);
        cyc(1'b0, 1'b1, 1'b1, 8'd99, 1'b0);
        idle(MSP + 2);
        check("no_99", 32'(speed), 32'd25);
        check("step_1", 32'(step), 32'd1);

        // 4: en low for 100 clocks mid-ms, command accepted meanwhile
        idle(7);
        cyc(1'b0, 1'b0, 1'b1, 8'd0, 1'b0);
        for (int i = 0; i < 99; i++) cyc(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        check("gap_pend", 32'(pending), 32'd1);
        idle(MSP + 2);
        check("speed_zero", 32'(speed), 32'd0);

        // 5: reset discards pending command
        cyc(1'b0, 1'b1, 1'b1, 8'd77, 1'b0);
        idle(5);
        cyc(1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
        check("rst_pend", 32'(pending), 32'd0);
        check("rst_speed2", 32'(speed), 32'd10);
        idle(2 * MSP + 5);
        check("no_77", 32'(speed), 32'd10);

        // 6: command in the tick_ms cycle waits a full ms
        to_tick_ms();
        cyc(1'b0, 1'b1, 1'b1, 8'd42, 1'b0);
        idle(MSP - 1);
        check("wait_next", 32'(speed), 32'd10);
        idle(2);
        check("applied_42", 32'(speed), 32'd42);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom_range(0, 299) == 0),
                ($urandom_range(0, 9) != 0),
                ($urandom_range(0, 4) == 0),
                8'($urandom),
                1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
